// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch responder: bus widths,
// enable levels and the fetch FSM state encoding.
package inst_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic RstEnable  = 1'b1;
  localparam logic ChipEnable = 1'b1;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FILL  = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Byte-wide instruction memory read port between the fetch unit (master)
// and the memory (slave).
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic                   mem_req;
  logic [InstAddrBus-1:0] mem_addr;
  logic [7:0]             mem_rdata;
  logic                   mem_rvalid;

  modport master (output mem_req, output mem_addr,
                  input  mem_rdata, input mem_rvalid);
  modport slave  (input  mem_req, input mem_addr,
                  output mem_rdata, output mem_rvalid);

endinterface

// File: rtl/inst_fetch_icache_array.sv
// Direct-mapped instruction cache storage: combinational read port,
// synchronous write port, valid bits cleared by rst.
module icache_array #(
  parameter int LINES = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);
  import inst_fetch_pkg::*;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch responder: cache lookup on pc, byte-wise line fill on a
// miss, registered instruction output towards IF/ID.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int LINES = 64,
  parameter int IDX_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [InstAddrBus-1:0] pc,
  input  logic                   flush,
  input  logic                   stall_i,
  output logic                   hit,
  output logic                   ifing,
  output logic [InstBus-1:0]     inst,
  output logic                   inst_valid,
  inst_fetch_if.master           mem
);

  localparam int TAG_W = InstAddrBus - IDX_W - 2;

  if_state_t  state, state_next;
  logic [1:0]  cnt;
  logic [29:0] fill_word;
  logic [23:0] asm_buf;

  logic             lookup_valid;
  logic [TAG_W-1:0] lookup_tag;
  logic [31:0]      lookup_data;
  logic             start_fill, idle_hit, last_byte, cache_we;
  logic [31:0]      fill_data;
  logic             unused_pc;

  assign unused_pc = ^pc[1:0];

  icache_array #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (pc[IDX_W+1:2]),
    .rd_valid(lookup_valid),
    .rd_tag  (lookup_tag),
    .rd_data (lookup_data),
    .we      (cache_we),
    .wr_idx  (fill_word[IDX_W-1:0]),
    .wr_tag  (fill_word[29:IDX_W]),
    .wr_data (fill_data)
  );

  assign start_fill = (state == IF_IDLE) && (ce == ChipEnable) && !hit && !stall_i && !flush;
  assign idle_hit   = (state == IF_IDLE) && (ce == ChipEnable) && hit && !stall_i && !flush;
  assign last_byte  = (state == IF_FILL) && mem.mem_rvalid && (cnt == 2'd3);
  // A flush coinciding with the final byte wins: the line stays untouched.
  assign cache_we   = last_byte && !flush;
  assign fill_data  = {mem.mem_rdata, asm_buf};

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state <= IF_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IF_IDLE:  if (start_fill) state_next = IF_FILL;
      IF_FILL: begin
        if (flush) begin
          state_next = mem.mem_rvalid ? IF_IDLE : IF_DRAIN;
        end else if (last_byte) begin
          state_next = IF_IDLE;
        end
      end
      IF_DRAIN: if (mem.mem_rvalid) state_next = IF_IDLE;
      default:  state_next = IF_IDLE;
    endcase
  end

  always_comb begin
    hit          = 1'b0;
    ifing        = (state != IF_IDLE);
    mem.mem_req  = 1'b0;
    mem.mem_addr = '0;
    case (state)
      IF_IDLE: hit = lookup_valid && (lookup_tag == pc[InstAddrBus-1:IDX_W+2]);
      IF_FILL: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = {fill_word, cnt};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt       <= 2'd0;
      fill_word <= '0;
      asm_buf   <= '0;
    end else if (start_fill) begin
      fill_word <= pc[InstAddrBus-1:2];
      cnt       <= 2'd0;
    end else if (state == IF_FILL) begin
      if (flush) begin
        cnt <= 2'd0;
      end else if (mem.mem_rvalid) begin
        cnt <= cnt + 2'd1;
        case (cnt)
          2'd0:    asm_buf[7:0]   <= mem.mem_rdata;
          2'd1:    asm_buf[15:8]  <= mem.mem_rdata;
          2'd2:    asm_buf[23:16] <= mem.mem_rdata;
          default: ;
        endcase
      end
    end
  end

  // Flush drops output even under stall; otherwise stall freezes it.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      inst       <= '0;
      inst_valid <= 1'b0;
    end else if (flush) begin
      inst_valid <= 1'b0;
    end else if (stall_i) begin
      inst_valid <= inst_valid;
    end else if (idle_hit) begin
      inst       <= lookup_data;
      inst_valid <= 1'b1;
    end else if (cache_we) begin
      inst       <= fill_data;
      inst_valid <= 1'b1;
    end else begin
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: a byte memory responder with variable
// latency plus a line-address cache model predicting every output each cycle.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, ce, flush, stall_i;
  logic [31:0] pc;
  logic        hit, ifing, inst_valid;
  logic [31:0] inst;

  inst_fetch_if mem_bus ();

  inst_fetch #(.LINES(64), .IDX_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .pc        (pc),
    .flush     (flush),
    .stall_i   (stall_i),
    .hit       (hit),
    .ifing     (ifing),
    .inst      (inst),
    .inst_valid(inst_valid),
    .mem       (mem_bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  byte unsigned memory [1024];
  bit           mem_busy;
  int           mem_wait;
  logic [31:0]  mem_paddr;
  bit           req_prev, rst_prev;
  logic [31:0]  addr_prev;
  int           max_lat = 1;
  logic [31:0]  done_addr [$];

  int           m_line [64];
  int unsigned  m_word [64];
  bit           m_fill, m_drain, m_valid;
  int unsigned  m_base;
  byte unsigned m_got [$];
  logic [31:0]  m_inst;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lineIdx(input logic [31:0] a);
    return int'((a >> 2) % 64);
  endfunction

  function automatic bit modelHit(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    return !(m_fill || m_drain) && (m_line[lineIdx(a)] == int'(w));
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 64; i++) m_line[i] = -1;
    m_fill = 0; m_drain = 0; m_valid = 0; m_inst = '0;
    m_got.delete();
  endtask

  // Memory answers a request after 1..max_lat cycles and holds it until then.
  task automatic memStep();
    int lat;
    if (rst_prev) begin
      mem_bus.mem_rvalid = 1'b0;
      mem_busy = 0;
    end else if (mem_bus.mem_rvalid) begin
      mem_bus.mem_rvalid = 1'b0;
      mem_bus.mem_rdata  = 8'($urandom);
    end else if (mem_busy) begin
      if (mem_wait == 0) begin
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = memory[mem_paddr[9:0]];
        mem_busy = 0;
      end else begin
        mem_wait--;
      end
    end else if (req_prev) begin
      lat = $urandom_range(max_lat, 1);
      if (lat == 1) begin
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = memory[addr_prev[9:0]];
      end else begin
        mem_busy  = 1;
        mem_wait  = lat - 2;
        mem_paddr = addr_prev;
      end
    end
  endtask

  task automatic modelUpdate();
    bit          produce = 0;
    int unsigned w = 0;
    if (rst) begin
      modelReset();
      return;
    end
    if (!m_fill && !m_drain) begin
      if (ce && !stall_i && !flush) begin
        if (modelHit(pc)) begin
          produce = 1;
          w = m_word[lineIdx(pc)];
        end else begin
          m_fill = 1;
          m_base = pc & 32'hFFFF_FFFC;
          m_got.delete();
        end
      end
    end else if (m_fill) begin
      if (flush) begin
        m_fill  = 0;
        m_drain = !mem_bus.mem_rvalid;
        m_got.delete();
      end else if (mem_bus.mem_rvalid) begin
        m_got.push_back(mem_bus.mem_rdata);
        if (m_got.size() == 4) begin
          for (int i = 3; i >= 0; i--) w = w * 256 + m_got[i];
          m_line[lineIdx(m_base)] = int'(m_base);
          m_word[lineIdx(m_base)] = w;
          m_fill  = 0;
          m_got.delete();
          produce = 1;
        end
      end
    end else if (mem_bus.mem_rvalid) begin
      m_drain = 0;
    end
    if (flush) m_valid = 0;
    else if (stall_i) m_valid = m_valid;
    else if (produce) begin m_inst = w; m_valid = 1; end
    else m_valid = 0;
  endtask

  // One clock cycle: drive inputs after the edge, check all outputs mid-cycle.
  task automatic applyStimulus(input bit i_rst, input bit i_ce, input logic [31:0] i_pc,
                               input bit i_flush, input bit i_stall);
    @(posedge clk);
    #1;
    memStep();
    rst = i_rst; ce = i_ce; pc = i_pc; flush = i_flush; stall_i = i_stall;
    @(negedge clk);
    checkOutput("hit",        hit,          modelHit(pc));
    checkOutput("ifing",      ifing,        m_fill || m_drain);
    checkOutput("mem_req",    mem_bus.mem_req,  m_fill);
    checkOutput("mem_addr",   mem_bus.mem_addr, m_fill ? 32'(m_base + m_got.size()) : 32'h0);
    checkOutput("inst",       inst,         m_inst);
    checkOutput("inst_valid", inst_valid,   m_valid);
    if (mem_bus.mem_req && mem_bus.mem_rvalid) done_addr.push_back(mem_bus.mem_addr);
    req_prev  = mem_bus.mem_req;
    addr_prev = mem_bus.mem_addr;
    rst_prev  = rst;
    modelUpdate();
  endtask

  initial begin
    logic [31:0] pool [12];
    logic [31:0] cur;
    int          snap [64];

    for (int i = 0; i < 1024; i++) memory[i] = 8'($urandom);
    memory[16] = 8'h13; memory[17] = 8'h05; memory[18] = 8'h10; memory[19] = 8'h00;
    rst = 1; ce = 0; pc = '0; flush = 0; stall_i = 0;
    mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
    mem_busy = 0; req_prev = 0; rst_prev = 1; addr_prev = '0;
    modelReset();
    @(posedge clk);
    applyStimulus(1, 0, 32'h0, 0, 0);

    // Cold miss at 0x10 with single-cycle memory latency.
    done_addr.delete();
    applyStimulus(0, 1, 32'h10, 0, 0);
    applyStimulus(0, 1, 32'h10, 0, 0);
    checkOutput("cold_ifing", ifing, 1);
    for (int k = 0; k < 8; k++) applyStimulus(0, 1, 32'h10, 0, 0);
    checkOutput("cold_inst",  inst, 32'h0010_0513);
    checkOutput("cold_valid", inst_valid, 1);
    checkOutput("cold_hit",   hit, 1);
    checkOutput("cold_nreq",  done_addr.size(), 4);
    for (int k = 0; k < 4 && k < done_addr.size(); k++)
      checkOutput("cold_addr", done_addr[k], 32'h10 + k);

    applyStimulus(0, 1, 32'h10, 0, 0);
    checkOutput("rehit_valid", inst_valid, 1);
    checkOutput("rehit_req",   mem_bus.mem_req, 0);

    // Conflict: 0x000 and 0x100 share index 0.
    for (int k = 0; k < 40 && !(inst_valid && !ifing && pc == 32'h0 && hit); k++)
      applyStimulus(0, 1, 32'h0, 0, 0);
    checkOutput("conf_fill0", hit, 1);
    applyStimulus(0, 1, 32'h100, 0, 0);
    for (int k = 0; k < 40 && !hit; k++) applyStimulus(0, 1, 32'h100, 0, 0);
    checkOutput("conf_fill100", hit, 1);
    applyStimulus(0, 1, 32'h0, 0, 0);
    checkOutput("conf_miss0", hit, 0);
    applyStimulus(0, 1, 32'h0, 0, 0);
    checkOutput("conf_refill", ifing, 1);
    for (int k = 0; k < 40 && ifing; k++) applyStimulus(0, 0, 32'h0, 0, 0);

    // Flush with the third byte outstanding.
    done_addr.delete();
    for (int k = 0; k < 20 && done_addr.size() < 2; k++) applyStimulus(0, 1, 32'h20, 0, 0);
    checkOutput("flush_two_bytes", done_addr.size(), 2);
    applyStimulus(0, 1, 32'h20, 1, 0);
    applyStimulus(0, 0, 32'h20, 0, 0);
    checkOutput("drain_ifing",  ifing, 1);
    checkOutput("drain_req",    mem_bus.mem_req, 0);
    checkOutput("drain_rvalid", mem_bus.mem_rvalid, 1);
    applyStimulus(0, 0, 32'h20, 0, 0);
    checkOutput("drain_done",   ifing, 0);
    checkOutput("flush_nohit",  hit, 0);
    checkOutput("flush_novalid", inst_valid, 0);

    // Stall across a hit, then a miss that must wait for release.
    applyStimulus(0, 1, 32'h10, 0, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 32'h30, 0, 1);
      checkOutput("stall_valid", inst_valid, 1);
      checkOutput("stall_inst",  inst, 32'h0010_0513);
      checkOutput("stall_nofill", ifing, 0);
    end
    applyStimulus(0, 1, 32'h30, 0, 0);
    applyStimulus(0, 1, 32'h30, 0, 0);
    checkOutput("stall_release", ifing, 1);
    for (int k = 0; k < 40 && ifing; k++) applyStimulus(0, 1, 32'h30, 0, 0);

    // Random phase with variable memory latency.
    max_lat = 3;
    for (int i = 0; i < 12; i++) pool[i] = $urandom_range(1023, 0);
    cur = pool[0];
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(3, 0) == 0) cur = pool[$urandom_range(11, 0)];
      applyStimulus($urandom_range(399, 0) == 0, $urandom_range(9, 0) != 0, cur,
                    $urandom_range(11, 0) == 0, $urandom_range(5, 0) == 0);
    end
    for (int k = 0; k < 20 && ifing; k++) applyStimulus(0, 0, cur, 0, 0);
    checkOutput("rand_settle", ifing, 0);

    // Reset after the second byte of a fill.
    max_lat = 1;
    done_addr.delete();
    for (int k = 0; k < 20 && done_addr.size() < 2; k++) applyStimulus(0, 1, 32'h440, 0, 0);
    checkOutput("rstfill_two_bytes", done_addr.size(), 2);
    for (int i = 0; i < 64; i++) snap[i] = m_line[i];
    applyStimulus(1, 1, 32'h440, 0, 0);
    applyStimulus(0, 0, 32'h440, 0, 0);
    checkOutput("rst_ifing",    ifing, 0);
    checkOutput("rst_inst",     inst, 0);
    checkOutput("rst_valid",    inst_valid, 0);
    checkOutput("rst_req",      mem_bus.mem_req, 0);
    checkOutput("rst_addr",     mem_bus.mem_addr, 0);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(0, 0, (snap[i] >= 0) ? 32'(snap[i]) : 32'(i * 4), 0, 0);
      checkOutput("rst_hit", hit, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch responder for the RISC-V core: the other end of the PC unit's `pc`/`ce` → `hit`/`ifing` handshake. Each cycle it looks up the word addressed by `pc` in a small direct-mapped instruction cache and reports `hit`. On a miss it fills the line over the byte-wide memory port, four little-endian bytes, and sets `ifing` while the fill runs. It drives the fetched instruction into IF/ID.

## Interface
Parameters:
- `LINES`, 64 — cache lines, one 32-bit word each; power of 2.
- `IDX_W`, 6 — log2(`LINES`).

Ports:
- `clk`  in  1  — the single clock.
- `rst`  in  1  — synchronous, active-high reset.
- `ce`  in  1  — PC unit enabled; when 0 no lookup and no fill starts.
- `pc`  in  32  — fetch address; `pc[1:0]` ignored (word-aligned access).
- `flush`  in  1  — jump taken; abort any fill, drop pending output.
- `stall_i`  in  1  — IF/ID not accepting; hold output, start no fill.
- `hit`  out  1  — combinational: the line for `pc` is valid and the tag matches.
- `ifing`  out  1  — a fill or drain is in progress (state ≠ IDLE).
- `inst`  out  32  — fetched instruction, registered.
- `inst_valid`  out  1  — `inst` is valid this cycle.
- `mem_req`  out  1  — byte read request; held until `mem_rvalid`.
- `mem_addr`  out  32  — byte address of the request.
- `mem_rdata`  in  8  — returned byte.
- `mem_rvalid`  in  1  — `mem_rdata` valid; completes the outstanding request.

## Operation
- Index = `pc[IDX_W+1:2]`; tag = `pc[31:IDX_W+2]`; one valid bit per line.
- States: IDLE, FILL, DRAIN.
- **IDLE**
  - If `ce & hit & ~stall_i & ~flush`: register `inst` = line data and assert `inst_valid`.
  - If `ce & ~hit & ~stall_i & ~flush`: latch `fill_addr = {pc[31:2],2'b00}`, clear byte count, go to FILL.
- **FILL**
  - `mem_req=1`, `mem_addr = fill_addr + cnt`.
  - On `mem_rvalid`, store `mem_rdata` into byte `cnt` of the assembly buffer (byte 0 → bits 7:0), then `cnt++`.
  - On the 4th byte: write data, tag and valid into the line; register `inst` = assembled word and assert `inst_valid`, unless `stall_i`, in which case the line is written but no output is produced; go to IDLE.
- **flush in FILL**
  - If no request is outstanding (`mem_rvalid` in the same cycle or between requests): go to IDLE.
  - Otherwise go to DRAIN.
  - The cache is never written by an aborted fill.
- **DRAIN**: `mem_req=0`; wait for `mem_rvalid`, discard the byte, go to IDLE.
- **flush in IDLE**: clears `inst_valid` next cycle; no lookup that cycle.
- **stall_i**: `inst` and `inst_valid` hold their value; an ongoing fill continues.
- `hit` is forced to 0 while state ≠ IDLE, so the PC unit never advances during a fill.
- **Conflict miss**: the fill overwrites the line; there is no victim handling (read-only cache).

## Timing
- Reset values: `hit`=0 (all valid bits cleared), `ifing`=0, `inst`=0, `inst_valid`=0, `mem_req`=0, `mem_addr`=0, state IDLE, `cnt`=0.
- Reset mid-fill aborts the fill immediately; the memory is reset by the same `rst`, so no drain is needed.
- **Hit path**: `pc` at cycle N → `hit` in N (combinational) → `inst`/`inst_valid` at N+1.
- **Miss, memory answering one cycle after request**:
  - Miss seen at N; FILL from N+1; bytes return at N+2, N+4, N+6, N+8, with each request issued in the cycle after the previous `mem_rvalid`.
  - Line valid and `inst_valid` at N+9.
  - `hit` for the same `pc` at N+9.
- `ifing` is high exactly while state ≠ IDLE.
- `flush` and the 4th `mem_rvalid` in the same cycle: `flush` wins; the line is not written.

## Structure
- Shared package, in `defines.v` style: state encodings (`IF_IDLE`, `IF_FILL`, `IF_DRAIN`), `InstAddrBus`/`InstBus` widths, `RstEnable`, `ChipEnable`.
- Sub-module `icache_array`: valid/tag/data storage with one combinational read port (index → valid, tag, data) and one synchronous write port. Valid bits are cleared on `rst`.
- The FSM, assembly buffer and output registers live in `inst_fetch`.

## Test plan
- **Cold miss**: reset, `ce=1`, `pc=0x0000_0010`, memory bytes `13 05 10 00`.
  - Expected: 4 requests to 0x10..0x13, `ifing` high.
  - Expected at N+9: `inst=0x0010_0513`, `inst_valid=1`, `hit=1`.
- **Hit after fill**: re-present `pc=0x10` → `hit`=1 in the same cycle, `inst` valid the next cycle, no `mem_req`.
- **Conflict**: fill 0x000, then fill 0x100 (same index 0).
  - Expected: `pc=0x000` misses again and a new fill is issued.
- **Flush mid-fill**: pulse `flush` with the 3rd byte outstanding.
  - Expected: DRAIN absorbs one `mem_rvalid`, then IDLE; line not valid; `inst_valid` stays 0.
- **stall_i**: hold `stall_i=1` across a hit.
  - Expected: `inst`/`inst_valid` frozen, no fill starts on a miss; released → normal behaviour resumes.
- **Reset mid-fill**: assert `rst` after the 2nd byte.
  - Expected: next cycle all outputs at their reset values, `hit`=0 for every address.
